// File: rtl/dot_product_pkg.sv
// Shared types and sizing helpers for the streaming dot-product engine.
package dot_product_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCUM  = ST_ACCUM,
    DRAIN  = ST_DRAIN,
    OUTPUT = ST_OUTPUT
  } state_e;

  localparam int DEF_LANES = 4;
  localparam int DEF_DW    = 8;

  typedef logic signed [DEF_LANES-1:0][DEF_DW-1:0] lane_vec_t;

  // Result width that holds LANES x MAX_LEN worst-case products without wrap.
  function automatic int calc_ow(input int lanes, input int dw, input int max_len);
    return 2*dw + $clog2(lanes) + $clog2(max_len) + 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/dp_mac_lanes.sv
// Registered per-lane signed multiplies followed by a combinational adder tree.
module dp_mac_lanes
  import dot_product_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 8,
  localparam int PW   = 2*DW,
  localparam int SW   = 2*DW + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vld_p0,
  input  logic [LANES*DW-1:0]     a_p0,
  input  logic [LANES*DW-1:0]     b_p0,
  output logic                    vld_p1,
  output logic signed [SW-1:0]    tree_sum_p1
);

  logic signed [PW-1:0] prod_p1 [LANES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  // S1: full-precision lane products, captured only for accepted beats
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      for (int i = 0; i < LANES; i++) begin
        prod_p1[i] <= $signed(a_p0[lane_lsb(i, DW) +: DW]) * $signed(b_p0[lane_lsb(i, DW) +: DW]);
      end
    end
  end

  always_comb begin
    tree_sum_p1 = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum_p1 = tree_sum_p1 + SW'(prod_p1[i]);
    end
  end

endmodule

// File: rtl/dot_product_stream.sv
// Streaming signed dot-product engine: accumulates LANES-wide beats over a job of len beats.
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int DW      = 8,
  parameter int MAX_LEN = 64,
  localparam int LW     = $clog2(MAX_LEN+1),
  localparam int OW     = calc_ow(LANES, DW, MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LW-1:0]        len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*DW-1:0]  inp1,
  input  logic [LANES*DW-1:0]  inp2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] sum,
  output logic                 busy
);

  localparam int SW = 2*DW + $clog2(LANES);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE       = LW'(1);

  state_e               state;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        beat_cnt;
  logic [LW-1:0]        len_clamped;
  logic                 vld_p0;
  logic                 vld_p1;
  logic                 vld_p2;
  logic signed [SW-1:0] tree_sum_p1;
  logic signed [OW-1:0] acc_p2;

  assign vld_p0      = in_valid && in_ready;
  assign len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;

  dp_mac_lanes #(.LANES(LANES), .DW(DW)) u_mac (
    .clk         (clk),
    .reset       (reset),
    .vld_p0      (vld_p0),
    .a_p0        (inp1),
    .b_p0        (inp2),
    .vld_p1      (vld_p1),
    .tree_sum_p1 (tree_sum_p1)
  );

  // S2: accumulate the lane-tree sum, cleared when a job starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      acc_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (state == IDLE && start) acc_p2 <= '0;
      else if (vld_p1)            acc_p2 <= acc_p2 + OW'(tree_sum_p1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      busy      <= 1'b0;
      beat_cnt  <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len_clamped;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (len_clamped == '0) begin
              sum       <= '0;
              out_valid <= 1'b1;
              state     <= OUTPUT;
            end else begin
              in_ready <= 1'b1;
              state    <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (vld_p0) begin
            beat_cnt <= beat_cnt + ONE;
            if (beat_cnt + ONE == len_q) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        // Result is only final once both pipeline stages have emptied
        DRAIN: begin
          if (!vld_p1 && !vld_p2) begin
            sum       <= acc_p2;
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
